register_file: RTL and testbench

- 32-entry general-purpose register file for the open-source processor core.
- Two registered read ports and one write-back port.
- A dedicated IO write path targets the IO register (default r31).
- An IO readback mode routes the IO register onto the rs1 output.
- Sits between decode/write-back and the IO block.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_bypass_mux.sv | 54 +++++
 rtl/register_file.sv | 118 +++++++++++
 tb/tb_register_file.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Shared defaults for the general-purpose register file: data width,
//   address width, the index of the IO register, and the data word type.
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IO_REG = 31;

    typedef logic [DATA_W-1:0] word_t;

endpackage : rf_pkg

// File: rtl/rf_bypass_mux.sv
// -----------------------------------------------------------------------------
// rf_bypass_mux
//   Produces the effective value of one register for a read. A write landing
//   on the same register at this clock edge is forwarded: IO write data
//   first, then write-back data, otherwise the stored value.
//
//   Optional feature: define RF_ZERO_REG_EN to make r0 always read as zero,
//   including on the forwarding path.
//
// Ports:
//   addr     in   register being read
//   regs     in   storage array contents
//   wr_en    in   write-back enable (already filtered for r0)
//   rd_addr  in   write-back address
//   rd_data  in   write-back data
//   io_en    in   IO write enable (already filtered for r0)
//   data_io  in   IO write data
//   eff      out  effective read value
// -----------------------------------------------------------------------------
module rf_bypass_mux
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int IO_REG = rf_pkg::IO_REG
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              io_en,
    input  logic [DATA_W-1:0] data_io,
    output logic [DATA_W-1:0] eff
);

    localparam logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_REG);

    always_comb begin
        // NOTE: eff gets a value on every path, starting with a default, so no latch is inferred.
        eff = regs[addr];
        if (io_en && (addr == IO_ADDR)) begin
            eff = data_io;
        end else if (wr_en && (addr == rd_addr)) begin
            eff = rd_data;
        end
`ifdef RF_ZERO_REG_EN
        if (addr == '0) begin
            eff = '0;
        end
`endif
    end

endmodule : rf_bypass_mux

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32-entry general-purpose register file with two registered read ports,
//   one write-back port and a dedicated IO write path into register IO_REG.
//   Reads capture the post-write value of this edge (write-through), with a
//   one-clock read latency. RF_from_IO routes IO_REG onto rs1_data.
//
//   Optional feature: define RF_ZERO_REG_EN to hard-wire r0 to zero (writes
//   to r0 discarded, r0 reads 0).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   we          in   write-back enable
//   RF_trigger  in   capture rs1/rs2 read data
//   RF_from_IO  in   capture IO_REG into rs1_data (ignored when RF_trigger)
//   io_we       in   IO write enable, writes data_io into IO_REG
//   rs1_addr    in   read port 1 address
//   rs2_addr    in   read port 2 address
//   rd_addr     in   write-back address
//   rd_data     in   write-back data
//   data_io     in   IO write data
//   rs1_data    out  registered read data, port 1
//   rs2_data    out  registered read data, port 2
// -----------------------------------------------------------------------------
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int IO_REG = rf_pkg::IO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              RF_trigger,
    input  logic              RF_from_IO,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] data_io,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_REG);

    logic [DATA_W-1:0] regs [DEPTH];

    logic              wr_en;     // write-back enable after r0 filtering
    logic              io_en;     // IO write enable after r0 filtering
    logic              wb_store;  // write-back actually lands (loses to IO on conflict)
    logic [ADDR_W-1:0] port1_addr;
    logic [DATA_W-1:0] eff1;
    logic [DATA_W-1:0] eff2;

    always_comb begin
        wr_en = we;
        io_en = io_we;
`ifdef RF_ZERO_REG_EN
        if (rd_addr == '0) wr_en = 1'b0;
        if (IO_ADDR == '0) io_en = 1'b0;
`endif
        wb_store = wr_en && !(io_en && (rd_addr == IO_ADDR));
    end

    // Port 1 serves both the normal read and the IO readback; RF_trigger wins.
    assign port1_addr = RF_trigger ? rs1_addr : IO_ADDR;

    rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_REG(IO_REG)) u_mux1 (
        .addr    (port1_addr),
        .regs    (regs),
        .wr_en   (wr_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .io_en   (io_en),
        .data_io (data_io),
        .eff     (eff1)
    );

    rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_REG(IO_REG)) u_mux2 (
        .addr    (rs2_addr),
        .regs    (regs),
        .wr_en   (wr_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .io_en   (io_en),
        .data_io (data_io),
        .eff     (eff2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole array is cleared on reset because software relies on
            // registers reading zero after reset; this keeps it out of RAM macros.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every read above sees pre-edge state.
            if (wb_store) regs[rd_addr] <= rd_data;
            if (io_en)    regs[IO_ADDR] <= data_io;

            if (RF_trigger) begin
                rs1_data <= eff1;
                rs2_data <= eff2;
            end else if (RF_from_IO) begin
                rs1_data <= eff1;
            end
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed self-checking bench for register_file with hand-computed
//   expected values. Inputs change 1 ns after a rising edge and outputs are
//   sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_register_file;
    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic              RF_trigger;
    logic              RF_from_IO;
    logic              io_we;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [ADDR_W-1:0] rd_addr;
    word_t             rd_data;
    word_t             data_io;
    word_t             rs1_data;
    word_t             rs2_data;

    int n_checks = 0;
    int n_fail   = 0;

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .RF_trigger (RF_trigger),
        .RF_from_IO (RF_from_IO),
        .io_we      (io_we),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .data_io    (data_io),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; RF_trigger = 1'b0; RF_from_IO = 1'b0; io_we = 1'b0;
    endtask

`ifdef RF_ZERO_REG_EN
    localparam word_t R0_EXP_A = 32'h0000_0000;
    localparam word_t R0_EXP_B = 32'h0000_0000;
`else
    localparam word_t R0_EXP_A = 32'hCAFE_BABE;
    localparam word_t R0_EXP_B = 32'h0000_0055;
`endif

    initial begin
        idle();
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0; data_io = '0;
        #1;

        // Reset
        rst = 1'b1; tick(); rst = 1'b0;
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);

        RF_trigger = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd4; tick(); idle();
        check("post_reset_rs1", rs1_data, 32'h0);
        check("post_reset_rs2", rs2_data, 32'h0);

        // Write-back then read
        we = 1'b1; rd_addr = 5'd1; rd_data = 32'hAAAA_BBBB; tick();
        rd_addr = 5'd2; rd_data = 32'h1234_5678; tick(); idle();
        RF_trigger = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd2; tick(); idle();
        check("read_r1", rs1_data, 32'hAAAA_BBBB);
        check("read_r2", rs2_data, 32'h1234_5678);

        // IO write then IO readback
        io_we = 1'b1; data_io = 32'hA1B2_C3D4; tick(); idle();
        RF_from_IO = 1'b1; tick(); idle();
        check("io_readback_rs1", rs1_data, 32'hA1B2_C3D4);
        check("io_readback_rs2_hold", rs2_data, 32'h1234_5678);

        // RF_trigger beats RF_from_IO, IO write still lands
        RF_trigger = 1'b1; RF_from_IO = 1'b1; io_we = 1'b1; data_io = 32'h1111_1111;
        rs1_addr = 5'd1; rs2_addr = 5'd2; tick(); idle();
        check("prio_rs1", rs1_data, 32'hAAAA_BBBB);
        check("prio_rs2", rs2_data, 32'h1234_5678);
        RF_from_IO = 1'b1; tick(); idle();
        check("prio_io_after", rs1_data, 32'h1111_1111);

        // Hold: no capture, writes do not disturb outputs
        rs1_addr = 5'd7; rs2_addr = 5'd8; we = 1'b1; rd_addr = 5'd7; rd_data = 32'hFFFF_0000;
        tick(); idle();
        check("hold_rs1", rs1_data, 32'h1111_1111);
        check("hold_rs2", rs2_data, 32'h1234_5678);

        // r0 behaviour (depends on RF_ZERO_REG_EN)
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hCAFE_BABE; tick(); idle();
        RF_trigger = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd7; tick(); idle();
        check("r0_read", rs1_data, R0_EXP_A);
        check("r7_read", rs2_data, 32'hFFFF_0000);
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'h0000_0055;
        RF_trigger = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0; tick(); idle();
        check("r0_bypass_rs1", rs1_data, R0_EXP_B);
        check("r0_bypass_rs2", rs2_data, R0_EXP_B);

        // Write conflict on IO_REG: io_we wins
        we = 1'b1; rd_addr = 5'd31; rd_data = 32'h5; io_we = 1'b1; data_io = 32'h7; tick(); idle();
        RF_trigger = 1'b1; rs1_addr = 5'd31; rs2_addr = 5'd1; tick(); idle();
        check("conflict_r31", rs1_data, 32'h7);
        check("conflict_r1", rs2_data, 32'hAAAA_BBBB);

        // Conflict seen through the bypass
        we = 1'b1; rd_addr = 5'd31; rd_data = 32'h8; io_we = 1'b1; data_io = 32'h9;
        RF_trigger = 1'b1; rs1_addr = 5'd31; rs2_addr = 5'd31; tick(); idle();
        check("conflict_bypass_rs1", rs1_data, 32'h9);
        check("conflict_bypass_rs2", rs2_data, 32'h9);

        // Dual writes to different targets both land
        we = 1'b1; rd_addr = 5'd6; rd_data = 32'h0606_0606; io_we = 1'b1; data_io = 32'h3131_3131;
        tick(); idle();
        RF_trigger = 1'b1; rs1_addr = 5'd6; rs2_addr = 5'd31; tick(); idle();
        check("dual_r6", rs1_data, 32'h0606_0606);
        check("dual_r31", rs2_data, 32'h3131_3131);

        // Write-back bypass
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'h9;
        RF_trigger = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd4; tick(); idle();
        check("wb_bypass_rs1", rs1_data, 32'h9);
        check("wb_bypass_rs2", rs2_data, 32'h0);
        RF_trigger = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd5; tick(); idle();
        check("wb_stored_r5", rs2_data, 32'h9);

        // IO readback bypass, rs2 holds
        io_we = 1'b1; data_io = 32'hDEAD_0001; RF_from_IO = 1'b1; tick(); idle();
        check("io_bypass_rs1", rs1_data, 32'hDEAD_0001);
        check("io_bypass_rs2_hold", rs2_data, 32'h9);

        // Reset mid-sequence overrides capture and writes
        rst = 1'b1; RF_trigger = 1'b1; we = 1'b1; rd_addr = 5'd1; rd_data = 32'hBAD0_BAD0;
        rs1_addr = 5'd1; rs2_addr = 5'd31; tick(); idle();
        check("mid_reset_rs1", rs1_data, 32'h0);
        check("mid_reset_rs2", rs2_data, 32'h0);
        RF_trigger = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd31; tick(); idle();
        check("cleared_r1", rs1_data, 32'h0);
        check("cleared_r31", rs2_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
